// File: rtl/mem_port_rr_arbiter_pkg.sv
// Shared types for the memory-port round-robin arbiter.
// Holds the arbiter FSM state encoding.
package arb_pkg;

    // IDLE: no transaction outstanding, arbitrate on pending requests.
    // BUSY: one requester owns the downstream port until mem_resp.
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

endpackage

// File: rtl/mem_port_rr_arbiter_rr_pick.sv
// Round-robin picker: first pending bit at or above ptr, wrapping.
// Ports: pending[N], ptr[s] in; onehot[N], idx[s] out (zero if none).
module rr_pick #(
    parameter int s = 1
) (
    input  logic [2**s-1:0] pending,
    input  logic [s-1:0]    ptr,
    output logic [2**s-1:0] onehot,
    output logic [s-1:0]    idx
);

    localparam int N = 2**s;

    logic         found;
    logic [s-1:0] j;

    // Walk N positions starting at ptr; the s-bit add wraps mod N.
    always_comb begin
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        j      = '0;
        for (int k = 0; k < N; k++) begin
            j = ptr + s'(k);
            if (!found && pending[j]) begin
                found     = 1'b1;
                idx       = j;
                onehot[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_rr_arbiter.sv
// Shares one downstream memory port among 2**s requesters, round-robin,
// holding the grant until mem_resp completes the transaction.
// Ports: req_read/req_write/req_addr/req_wdata in, req_resp/req_rdata out
// per requester; grant one-hot out; mem_read/mem_write/mem_addr/mem_wdata
// out and mem_resp/mem_rdata in toward memory. clk, rst (async, high).
module mem_port_rr_arbiter
    import arb_pkg::*;
#(
    parameter int s          = 1,
    parameter int addr_width = 32,
    parameter int data_width = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2**s-1:0]       req_read,
    input  logic [2**s-1:0]       req_write,
    input  logic [addr_width-1:0] req_addr  [2**s],
    input  logic [data_width-1:0] req_wdata [2**s],
    output logic [2**s-1:0]       req_resp,
    output logic [data_width-1:0] req_rdata,
    output logic [2**s-1:0]       grant,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [addr_width-1:0] mem_addr,
    output logic [data_width-1:0] mem_wdata,
    input  logic                  mem_resp,
    input  logic [data_width-1:0] mem_rdata
);

    localparam int N = 2**s;

    // Downstream command; widths follow this instance's parameters,
    // so the struct lives here rather than in the shared package.
    typedef struct packed {
        logic                  read;
        logic                  write;
        logic [addr_width-1:0] addr;
        logic [data_width-1:0] wdata;
    } mem_cmd_t;

    arb_state_e state, state_nxt;

    logic [N-1:0] pending;
    logic [N-1:0] pick_oh;
    logic [s-1:0] pick_idx;
    logic [s-1:0] ptr;
    logic [s-1:0] widx;
    mem_cmd_t     cmd;
    mem_cmd_t     cmd_sel;

    assign pending = req_read | req_write;

    rr_pick #(
        .s (s)
    ) u_pick (
        .pending (pending),
        .ptr     (ptr),
        .onehot  (pick_oh),
        .idx     (pick_idx)
    );

    // One-hot AND-OR mux of the requester command fields.
    // Write wins when a requester raises both read and write.
    always_comb begin
        cmd_sel = '0;
        for (int i = 0; i < N; i++) begin
            cmd_sel.addr  = cmd_sel.addr
                          | (req_addr[i] & {addr_width{pick_oh[i]}});
            cmd_sel.wdata = cmd_sel.wdata
                          | (req_wdata[i] & {data_width{pick_oh[i]}});
        end
        cmd_sel.write = |(pick_oh & req_write);
        cmd_sel.read  = !cmd_sel.write && |(pick_oh & req_read);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (|pending) state_nxt = BUSY;
            BUSY: if (mem_resp) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: completion strobe goes to the current owner only.
    always_comb begin
        req_resp  = '0;
        req_rdata = mem_rdata;
        if (state == BUSY && mem_resp) begin
            req_resp = grant;
        end
    end

    // Grant, pointer and latched command. Requester-side changes after
    // the grant edge are ignored until the transaction completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant <= '0;
            ptr   <= '0;
            widx  <= '0;
            cmd   <= '0;
        end else if (state == IDLE) begin
            if (|pending) begin
                grant <= pick_oh;
                widx  <= pick_idx;
                cmd   <= cmd_sel;
            end
        end else if (mem_resp) begin
            grant     <= '0;
            cmd.read  <= 1'b0;
            cmd.write <= 1'b0;
            ptr       <= widx + s'(1);
        end
    end

    assign mem_read  = cmd.read;
    assign mem_write = cmd.write;
    assign mem_addr  = cmd.addr;
    assign mem_wdata = cmd.wdata;

endmodule

// File: tb/tb_mem_port_rr_arbiter.sv
// Randomized scoreboard bench for mem_port_rr_arbiter (4 requesters).
// Reference model arbitrates with plain modular arithmetic.
module tb_mem_port_rr_arbiter;

    localparam int S  = 2;
    localparam int N  = 4;
    localparam int AW = 16;
    localparam int DW = 64;
    localparam int CYCLES = 3000;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [N-1:0]  req_read  = '0;
    logic [N-1:0]  req_write = '0;
    logic [AW-1:0] req_addr  [N];
    logic [DW-1:0] req_wdata [N];
    logic [N-1:0]  req_resp;
    logic [DW-1:0] req_rdata;
    logic [N-1:0]  grant;
    logic          mem_read, mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_resp  = 1'b0;
    logic [DW-1:0] mem_rdata = '0;

    mem_port_rr_arbiter #(
        .s          (S),
        .addr_width (AW),
        .data_width (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_read  (req_read),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_resp  (req_resp),
        .req_rdata (req_rdata),
        .grant     (grant),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_resp  (mem_resp),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string nm, input logic [127:0] act,
                         input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [N-1:0]  grant;
        logic          rd;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } exp_t;

    exp_t expq[$];

    // Reference model: one owner at a time; next search starts one past
    // the last winner; write beats read for the same requester.
    int m_ptr  = 0;
    int m_win  = 0;
    bit m_busy = 0;

    always @(posedge clk or posedge rst) begin
        logic [N-1:0] pend;
        exp_t e;
        if (rst) begin
            m_busy = 0;
            m_ptr  = 0;
            expq.delete();
        end else if (m_busy) begin
            if (mem_resp) begin
                m_busy = 0;
                m_ptr  = (m_win + 1) % N;
            end
        end else begin
            pend = req_read | req_write;
            if (pend != 0) begin
                for (int k = 0; k < N; k++) begin
                    if (!m_busy && pend[(m_ptr + k) % N]) begin
                        m_win   = (m_ptr + k) % N;
                        m_busy  = 1;
                    end
                end
                e.grant = '0;
                e.grant[m_win] = 1'b1;
                e.wr    = req_write[m_win];
                e.rd    = !req_write[m_win];
                e.addr  = req_addr[m_win];
                e.wdata = req_wdata[m_win];
                expq.push_back(e);
            end
        end
    end

    // Monitor: pops an expectation whenever a new command appears.
    bit   active = 0;
    exp_t cur;

    always @(posedge rst) active = 0;

    always @(negedge clk) begin
        logic [N-1:0] exp_resp;
        #2;
        if (!rst) begin
            check("grant_onehot0", 128'($onehot0(grant)), 128'(1));
            check("rd_wr_excl", 128'(mem_read & mem_write), 128'(0));
            if (mem_read | mem_write) begin
                if (!active) begin
                    if (expq.size() == 0) begin
                        check("unexpected_cmd_grant", 128'(grant), 128'(0));
                    end else begin
                        cur    = expq.pop_front();
                        active = 1;
                        check("grant", 128'(grant), 128'(cur.grant));
                        check("mem_read", 128'(mem_read), 128'(cur.rd));
                        check("mem_write", 128'(mem_write), 128'(cur.wr));
                        check("mem_addr", 128'(mem_addr), 128'(cur.addr));
                        check("mem_wdata", 128'(mem_wdata), 128'(cur.wdata));
                    end
                end else begin
                    check("hold_grant", 128'(grant), 128'(cur.grant));
                    check("hold_addr", 128'(mem_addr), 128'(cur.addr));
                    check("hold_wdata", 128'(mem_wdata), 128'(cur.wdata));
                    check("hold_op", 128'({mem_read, mem_write}),
                          128'({cur.rd, cur.wr}));
                end
            end else begin
                check("idle_grant", 128'(grant), 128'(0));
                if (active) begin
                    check("cmd_dropped_early", 128'(mem_read | mem_write),
                          128'(1));
                    active = 0;
                end
                if (expq.size() != 0)
                    check("grant_latency", 128'(grant), 128'(expq[0].grant));
            end
            exp_resp = (active && mem_resp) ? cur.grant : '0;
            check("req_resp", 128'(req_resp), 128'(exp_resp));
            if (mem_resp)
                check("req_rdata", 128'(req_rdata), 128'(mem_rdata));
            if (active && mem_resp) active = 0;
        end
    end

    // Stimulus: requesters, memory responder, one mid-transaction reset.
    logic [N-1:0] holding  = '0;
    logic [N-1:0] resp_pend = '0;
    int           delay    = 0;
    bit           want_rst = 0;
    bit           rst_done = 0;

    initial begin
        for (int i = 0; i < N; i++) begin
            req_addr[i]  = '0;
            req_wdata[i] = '0;
        end
        #1 rst = 1'b1;
        #1;
        check("rst_grant", 128'(grant), 128'(0));
        check("rst_mem_read", 128'(mem_read), 128'(0));
        check("rst_mem_write", 128'(mem_write), 128'(0));
        check("rst_mem_addr", 128'(mem_addr), 128'(0));
        check("rst_mem_wdata", 128'(mem_wdata), 128'(0));
        check("rst_req_resp", 128'(req_resp), 128'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int cyc = 0; cyc < CYCLES; cyc++) begin
            @(negedge clk);
            if (cyc == CYCLES / 2) want_rst = 1;
            for (int i = 0; i < N; i++) begin
                if (resp_pend[i]) begin
                    req_read[i]  = 1'b0;
                    req_write[i] = 1'b0;
                    holding[i]   = 1'b0;
                end else if (!holding[i] && $urandom_range(0, 99) < 40) begin
                    int op;
                    op           = $urandom_range(0, 2);
                    holding[i]   = 1'b1;
                    req_read[i]  = (op != 1);
                    req_write[i] = (op != 0);
                    req_addr[i]  = AW'($urandom);
                    req_wdata[i] = {$urandom, $urandom};
                end else if (holding[i] && $urandom_range(0, 99) < 15) begin
                    req_addr[i]  = AW'($urandom);
                    req_wdata[i] = {$urandom, $urandom};
                end
            end
            if (mem_read | mem_write) begin
                if (delay == 0) begin
                    mem_resp  = 1'b1;
                    mem_rdata = {$urandom, $urandom};
                    delay     = $urandom_range(0, 4);
                end else begin
                    mem_resp = 1'b0;
                    delay--;
                end
            end else begin
                mem_resp  = ($urandom_range(0, 9) == 0);
                mem_rdata = {$urandom, $urandom};
            end
            #1 resp_pend = req_resp;
            if (want_rst && (mem_read | mem_write) && !mem_resp) begin
                #2 rst = 1'b1;
                #1;
                check("async_rst_grant", 128'(grant), 128'(0));
                check("async_rst_read", 128'(mem_read), 128'(0));
                check("async_rst_write", 128'(mem_write), 128'(0));
                req_read  = '0;
                req_write = '0;
                holding   = '0;
                resp_pend = '0;
                mem_resp  = 1'b0;
                delay     = 0;
                @(negedge clk);
                rst      = 1'b0;
                want_rst = 0;
                rst_done = 1;
            end
        end

        if (!rst_done) begin
            failures++;
            $display("FAIL rst_injection actual=0 required=1");
        end
        @(negedge clk);
        #5;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
